// File: rtl/pim_mem_pkg.sv
// Shared definitions for the PIM DRAM responder.
//   DATA_W_DEF / ADDR_W_DEF : default bus data and byte-address widths
//   wq_entry_t              : one queued write address (word index + window flag)
//   addr_to_idx()           : byte address -> word index relative to a window base
package pim_mem_pkg;

    localparam int DATA_W_DEF = 256;
    localparam int ADDR_W_DEF = 32;

    // The index is kept at full address width.  The window check can then
    // be repeated on the stored value without knowing MEM_DEPTH here.
    typedef struct packed {
        logic [ADDR_W_DEF-1:0] idx;
        logic                  oob;
    } wq_entry_t;

    // Offset from the window base, then drop the byte-within-word bits.
    // Addresses below the base wrap to large values, which the caller
    // rejects separately with an explicit lower-bound compare.
    function automatic logic [ADDR_W_DEF-1:0] addr_to_idx(
        input logic [ADDR_W_DEF-1:0] addr,
        input logic [ADDR_W_DEF-1:0] base,
        input int unsigned           shift
    );
        logic [ADDR_W_DEF-1:0] offset;
        offset = addr - base;
        return offset >> shift;
    endfunction

endpackage

// File: rtl/pim_dram_resp_model_if.sv
// Memory-bus bundle between Device_top (master) and the DRAM responder (slave).
//   read_en / write_en / addr_in : read and write-address commands
//   wr_data_valid / wr_data      : write data beats (PIM results)
//   rd_data_valid / data_bus_from_memory / rd_err : read response beats
interface pim_dram_resp_model_if
    import pim_mem_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
);

    logic              read_en;
    logic              write_en;
    logic [ADDR_W-1:0] addr_in;
    logic              wr_data_valid;
    logic [DATA_W-1:0] wr_data;
    logic              rd_data_valid;
    logic [DATA_W-1:0] data_bus_from_memory;
    logic              rd_err;

    modport master (
        output read_en, write_en, addr_in, wr_data_valid, wr_data,
        input  rd_data_valid, data_bus_from_memory, rd_err
    );

    modport slave (
        input  read_en, write_en, addr_in, wr_data_valid, wr_data,
        output rd_data_valid, data_bus_from_memory, rd_err
    );

endinterface

// File: rtl/pim_wq_fifo.sv
// Write-address FIFO.
//   clk, rst_x        : clock, asynchronous active-low reset
//   push, push_entry  : enqueue request and entry
//   pop               : dequeue request (ignored while empty)
//   head_entry        : current head, valid while !empty
//   count/full/empty  : occupancy status
// A push while full is accepted only when a pop happens in the same cycle;
// the slot being freed is the one the push overwrites.
module pim_wq_fifo
    import pim_mem_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_x,
    input  logic                     push,
    input  wq_entry_t                push_entry,
    input  logic                     pop,
    output wq_entry_t                head_entry,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    wq_entry_t          store [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_reg;
    logic [PTR_W-1:0]   rd_ptr_reg;
    logic [CNT_W-1:0]   count_reg;
    logic               do_push;
    logic               do_pop;

    assign full       = (count_reg == CNT_W'(DEPTH));
    assign empty      = (count_reg == '0);
    assign count      = count_reg;
    assign head_entry = store[rd_ptr_reg];

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || pop);

    // Storage carries no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            store[wr_ptr_reg] <= push_entry;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_x) begin
        if (!rst_x) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            count_reg <= count_reg + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

endmodule

// File: rtl/pim_dram_resp_model.sv
// DRAM-side responder for one address window.
//   clk, rst_x    : clock, asynchronous active-low reset
//   bus (slave)   : read/write-address commands, write data, read responses
//   init_*        : backdoor preload of one word per cycle
//   wq_count      : write-address FIFO occupancy
//   wq_overflow   : sticky, a write address was dropped on a full FIFO
//   wq_underflow  : sticky, a data beat arrived with no address to pair with
//   err_cnt       : saturating count of out-of-window reads and writes
// Reads return mem[idx] RD_LATENCY cycles after issue; write addresses are
// queued and consumed by later data beats in order.
module pim_dram_resp_model
    import pim_mem_pkg::*;
#(
    parameter int                DATA_W     = DATA_W_DEF,
    parameter int                ADDR_W     = ADDR_W_DEF,
    parameter int                MEM_DEPTH  = 1024,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = 32'h0100_0000,
    parameter int                RD_LATENCY = 4,
    parameter int                WQ_DEPTH   = 16
) (
    input  logic                           clk,
    input  logic                           rst_x,
    pim_dram_resp_model_if.slave           bus,
    input  logic                           init_en,
    input  logic [$clog2(MEM_DEPTH)-1:0]   init_idx,
    input  logic [DATA_W-1:0]              init_data,
    output logic [$clog2(WQ_DEPTH):0]      wq_count,
    output logic                           wq_overflow,
    output logic                           wq_underflow,
    output logic [15:0]                    err_cnt
);

    localparam int                    IDX_W      = $clog2(MEM_DEPTH);
    localparam int                    BYTE_SHIFT = $clog2(DATA_W / 8);
    localparam logic [ADDR_W_DEF-1:0] BASE_EXT   = ADDR_W_DEF'(BASE_ADDR);
    localparam logic [ADDR_W_DEF-1:0] DEPTH_EXT  = ADDR_W_DEF'(MEM_DEPTH);

    // ------------------------------------------------------------------
    // Address decode, shared by read_en and write_en
    // ------------------------------------------------------------------
    logic [ADDR_W_DEF-1:0] addr_ext;
    logic [ADDR_W_DEF-1:0] idx_full;
    logic [IDX_W-1:0]      acc_idx;
    logic                  acc_oob;

    assign addr_ext = ADDR_W_DEF'(bus.addr_in);
    assign idx_full = addr_to_idx(addr_ext, BASE_EXT, BYTE_SHIFT);
    assign acc_oob  = (addr_ext < BASE_EXT) || (idx_full >= DEPTH_EXT);
    assign acc_idx  = idx_full[IDX_W-1:0];

    // ------------------------------------------------------------------
    // Write-address queue and data pairing
    // ------------------------------------------------------------------
    wq_entry_t push_entry;
    wq_entry_t head_entry;
    logic      fifo_full;
    logic      fifo_empty;
    logic      fifo_push;
    logic      fifo_pop;
    logic      bypass;
    logic      head_oob;

    assign push_entry = '{idx: idx_full, oob: acc_oob};

    // A data beat meeting an empty queue pairs directly with a same-cycle
    // write address, so neither touches the FIFO.
    assign bypass    = bus.wr_data_valid && bus.write_en && fifo_empty;
    assign fifo_push = bus.write_en && !bypass;
    assign fifo_pop  = bus.wr_data_valid && !fifo_empty;

    // Re-checking the stored index keeps a beat from landing outside the
    // array even if only the low index bits were meaningful.
    assign head_oob = head_entry.oob || (head_entry.idx >= DEPTH_EXT);

    pim_wq_fifo #(
        .DEPTH (WQ_DEPTH)
    ) u_wq_fifo (
        .clk        (clk),
        .rst_x      (rst_x),
        .push       (fifo_push),
        .push_entry (push_entry),
        .pop        (fifo_pop),
        .head_entry (head_entry),
        .count      (wq_count),
        .full       (fifo_full),
        .empty      (fifo_empty)
    );

    logic             mem_we;
    logic [IDX_W-1:0] mem_widx;

    always_comb begin
        mem_we   = 1'b0;
        mem_widx = acc_idx;
        if (bypass) begin
            mem_we   = !acc_oob;
            mem_widx = acc_idx;
        end else if (fifo_pop) begin
            mem_we   = !head_oob;
            mem_widx = head_entry.idx[IDX_W-1:0];
        end
    end

    // ------------------------------------------------------------------
    // Memory array and read data pipeline
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] mem       [MEM_DEPTH];
    logic [DATA_W-1:0] data_pipe [RD_LATENCY];

    // Non-blocking writes make a same-cycle read see the old word.  The
    // init write is issued last so it wins a collision with a data beat.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_widx] <= bus.wr_data;
        end
        if (init_en) begin
            mem[init_idx] <= init_data;
        end
        data_pipe[0] <= mem[acc_idx];
        for (int i = 1; i < RD_LATENCY; i++) begin
            data_pipe[i] <= data_pipe[i-1];
        end
    end

    logic [RD_LATENCY-1:0] valid_pipe_reg;
    logic [RD_LATENCY-1:0] err_pipe_reg;

    always_ff @(posedge clk or negedge rst_x) begin
        if (!rst_x) begin
            valid_pipe_reg <= '0;
            err_pipe_reg   <= '0;
        end else begin
            valid_pipe_reg[0] <= bus.read_en;
            err_pipe_reg[0]   <= bus.read_en && acc_oob;
            for (int i = 1; i < RD_LATENCY; i++) begin
                valid_pipe_reg[i] <= valid_pipe_reg[i-1];
                err_pipe_reg[i]   <= err_pipe_reg[i-1];
            end
        end
    end

    // The data stages are not reset, so the bus is forced to zero whenever
    // no good beat is presented (idle, after reset, out-of-window read).
    assign bus.rd_data_valid        = valid_pipe_reg[RD_LATENCY-1];
    assign bus.rd_err               = err_pipe_reg[RD_LATENCY-1];
    assign bus.data_bus_from_memory =
        (valid_pipe_reg[RD_LATENCY-1] && !err_pipe_reg[RD_LATENCY-1])
            ? data_pipe[RD_LATENCY-1] : '0;

    // ------------------------------------------------------------------
    // Sticky flags and error counter
    // ------------------------------------------------------------------
    logic        overflow_reg;
    logic        underflow_reg;
    logic [15:0] err_cnt_reg;
    logic [15:0] err_cnt_next;
    logic [1:0]  err_inc;
    logic [16:0] err_sum;

    // A read and a write in the same cycle are two separate accesses.
    assign err_inc      = {1'b0, bus.read_en && acc_oob} + {1'b0, bus.write_en && acc_oob};
    assign err_sum      = {1'b0, err_cnt_reg} + {15'd0, err_inc};
    assign err_cnt_next = err_sum[16] ? 16'hFFFF : err_sum[15:0];

    always_ff @(posedge clk or negedge rst_x) begin
        if (!rst_x) begin
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
            err_cnt_reg   <= '0;
        end else begin
            if (bus.write_en && fifo_full && !fifo_pop) begin
                overflow_reg <= 1'b1;
            end
            if (bus.wr_data_valid && fifo_empty && !bus.write_en) begin
                underflow_reg <= 1'b1;
            end
            err_cnt_reg <= err_cnt_next;
        end
    end

    assign wq_overflow  = overflow_reg;
    assign wq_underflow = underflow_reg;
    assign err_cnt      = err_cnt_reg;

endmodule

// File: tb/tb_pim_dram_resp_model.sv
// Bench for pim_dram_resp_model: queue-based reference model checked every
// cycle, a table of window-decode reads, and directed FIFO/reset sequences.
module tb_pim_dram_resp_model;

    localparam int          DW    = 256;
    localparam int          AW    = 32;
    localparam int          DEPTH = 1024;
    localparam int          LAT   = 4;
    localparam int          WQD   = 16;
    localparam logic [31:0] BASE  = 32'h0100_0000;

    logic clk = 1'b0;
    logic rst_x = 1'b0;
    always #5 clk = ~clk;

    pim_dram_resp_model_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    logic          init_en;
    logic [9:0]    init_idx;
    logic [DW-1:0] init_data;
    logic [4:0]    wq_count;
    logic          wq_overflow;
    logic          wq_underflow;
    logic [15:0]   err_cnt;

    pim_dram_resp_model #(
        .DATA_W(DW), .ADDR_W(AW), .MEM_DEPTH(DEPTH), .BASE_ADDR(BASE),
        .RD_LATENCY(LAT), .WQ_DEPTH(WQD)
    ) dut (
        .clk(clk), .rst_x(rst_x), .bus(bus),
        .init_en(init_en), .init_idx(init_idx), .init_data(init_data),
        .wq_count(wq_count), .wq_overflow(wq_overflow),
        .wq_underflow(wq_underflow), .err_cnt(err_cnt)
    );

    typedef struct {
        logic          re;
        logic          we;
        logic [31:0]   addr;
        logic          wdv;
        logic [DW-1:0] wd;
        logic          ie;
        logic [9:0]    ii;
        logic [DW-1:0] id;
    } stim_t;

    typedef struct {
        int            due;
        logic [DW-1:0] data;
        logic          err;
    } beat_t;

    typedef struct {
        int idx;
        bit oob;
    } went_t;

    typedef struct {
        logic [31:0]   addr;
        logic [DW-1:0] exp_data;
        logic          exp_err;
    } rd_vec_t;

    // Reference model state
    logic [DW-1:0] m_mem [DEPTH];
    beat_t         exp_q[$];
    went_t         m_wq[$];
    bit            m_ovf;
    bit            m_unf;
    int            m_err;

    int t;
    int checks;
    int errors;
    int beats;
    int last_beat_t;

    logic [DW-1:0] pat_p;
    logic [DW-1:0] q0;
    logic [DW-1:0] q1;
    logic [DW-1:0] zw;
    rd_vec_t       tbl [7];

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0d actual=%0h required=%0h", name, t, act, exp);
        end
    endtask

    function automatic stim_t idle_stim();
        stim_t s;
        s.re = 1'b0; s.we = 1'b0; s.addr = '0; s.wdv = 1'b0; s.wd = '0;
        s.ie = 1'b0; s.ii = '0; s.id = '0;
        return s;
    endfunction

    function automatic logic [DW-1:0] rand_word();
        logic [DW-1:0] w;
        for (int k = 0; k < DW / 32; k++) w[k*32 +: 32] = $urandom;
        return w;
    endfunction

    // Window rule: word = (addr - base) / bytes-per-word, valid below DEPTH.
    function automatic void decode(input logic [31:0] a, output int idx, output bit oob);
        int unsigned word;
        word = (a - BASE) / (DW / 8);
        oob  = (a < BASE) || (word >= DEPTH);
        idx  = oob ? 0 : int'(word);
    endfunction

    task automatic drive(input stim_t s);
        bus.read_en       = s.re;
        bus.write_en      = s.we;
        bus.addr_in       = s.addr;
        bus.wr_data_valid = s.wdv;
        bus.wr_data       = s.wd;
        init_en           = s.ie;
        init_idx          = s.ii;
        init_data         = s.id;
    endtask

    task automatic check_outputs();
        beat_t b;
        bit    ev;
        ev = 1'b0;
        b.data = '0;
        b.err = 1'b0;
        if (exp_q.size() > 0 && exp_q[0].due == t) begin
            b  = exp_q.pop_front();
            ev = 1'b1;
        end
        if (bus.rd_data_valid === 1'b1) begin
            beats++;
            last_beat_t = t;
        end
        chk("rd_data_valid", DW'(bus.rd_data_valid), DW'(ev));
        chk("data_bus", bus.data_bus_from_memory, ev ? b.data : zw);
        chk("rd_err", DW'(bus.rd_err), DW'(ev && b.err));
        chk("wq_count", DW'(wq_count), DW'(m_wq.size()));
        chk("wq_overflow", DW'(wq_overflow), DW'(m_ovf));
        chk("wq_underflow", DW'(wq_underflow), DW'(m_unf));
        chk("err_cnt", DW'(err_cnt), DW'(m_err));
    endtask

    task automatic model_update(input stim_t s);
        int    idx;
        bit    oob;
        int    sz;
        bit    popped;
        beat_t b;
        went_t e;
        decode(s.addr, idx, oob);
        if (s.re) begin
            b.due  = t + LAT;
            b.data = oob ? zw : m_mem[idx];
            b.err  = oob;
            exp_q.push_back(b);
        end
        if (s.re && oob) m_err++;
        if (s.we && oob) m_err++;
        if (m_err > 65535) m_err = 65535;
        sz = m_wq.size();
        popped = 1'b0;
        if (s.wdv) begin
            if (sz == 0) begin
                if (s.we) begin
                    if (!oob) m_mem[idx] = s.wd;
                end else begin
                    m_unf = 1'b1;
                end
            end else begin
                e = m_wq.pop_front();
                popped = 1'b1;
                if (!e.oob) m_mem[e.idx] = s.wd;
            end
        end
        if (s.we && !(s.wdv && sz == 0)) begin
            if (sz < WQD || popped) begin
                e.idx = idx;
                e.oob = oob;
                m_wq.push_back(e);
            end else begin
                m_ovf = 1'b1;
            end
        end
        if (s.ie) m_mem[s.ii] = s.id;
    endtask

    task automatic step_cycle(input stim_t s);
        check_outputs();
        drive(s);
        model_update(s);
        @(posedge clk);
        @(negedge clk);
        t++;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) step_cycle(idle_stim());
    endtask

    task automatic apply_reset(input int n);
        drive(idle_stim());
        rst_x = 1'b0;
        #1;
        exp_q.delete();
        m_wq.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
        m_err = 0;
        chk("rst_valid", DW'(bus.rd_data_valid), zw);
        chk("rst_data", bus.data_bus_from_memory, zw);
        chk("rst_err", DW'(bus.rd_err), zw);
        chk("rst_wq_count", DW'(wq_count), zw);
        chk("rst_overflow", DW'(wq_overflow), zw);
        chk("rst_underflow", DW'(wq_underflow), zw);
        chk("rst_err_cnt", DW'(err_cnt), zw);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
            t++;
        end
        rst_x = 1'b1;
    endtask

    // Single read with the beat checked exactly LAT cycles after issue.
    task automatic read_expect(input string name, input logic [31:0] a,
                               input logic [DW-1:0] ed, input logic ee);
        stim_t s;
        s = idle_stim();
        s.re = 1'b1;
        s.addr = a;
        step_cycle(s);
        idle_cycles(LAT - 1);
        chk({name, "_valid"}, DW'(bus.rd_data_valid), DW'(1));
        chk({name, "_data"}, bus.data_bus_from_memory, ed);
        chk({name, "_err"}, DW'(bus.rd_err), DW'(ee));
        idle_cycles(1);
    endtask

    initial begin
        stim_t s;
        int    t0;
        int    ridx;
        bit    roob;

        checks = 0; errors = 0; t = 0; beats = 0; last_beat_t = -1;
        m_ovf = 1'b0; m_unf = 1'b0; m_err = 0;
        zw = '0;
        for (int k = 0; k < 16; k++) pat_p[k*16 +: 16] = 16'h3e40 + 16'(k);
        q0 = {8{32'hC0DE_0000}};
        q1 = {8{32'hFACE_03FF}};

        tbl[0] = '{32'h0100_2000, pat_p, 1'b0};
        tbl[1] = '{32'h0100_201F, pat_p, 1'b0};
        tbl[2] = '{BASE,          q0,    1'b0};
        tbl[3] = '{32'h0100_7FE0, q1,    1'b0};
        tbl[4] = '{32'h0100_8000, zw,    1'b1};
        tbl[5] = '{32'h0080_0000, zw,    1'b1};
        tbl[6] = '{32'h00FF_FFE0, zw,    1'b1};

        apply_reset(3);

        // Preload every word so the model knows the whole array.
        for (int i = 0; i < DEPTH; i++) begin
            s = idle_stim();
            s.ie = 1'b1;
            s.ii = 10'(i);
            s.id = (i == 256) ? pat_p : (i == 0) ? q0 : (i == DEPTH - 1) ? q1 : rand_word();
            step_cycle(s);
        end

        // Window decode and latency table
        for (int i = 0; i < 7; i++) read_expect("tbl", tbl[i].addr, tbl[i].exp_data, tbl[i].exp_err);

        // 256-beat stream
        beats = 0;
        t0 = t;
        for (int i = 0; i < 256; i++) begin
            s = idle_stim();
            s.re = 1'b1;
            s.addr = 32'h0100_2000 + 32'(i * 32);
            step_cycle(s);
        end
        idle_cycles(LAT + 1);
        chk("stream_beats", DW'(beats), DW'(256));
        chk("stream_last", DW'(last_beat_t), DW'(t0 + 255 + LAT));

        // Write pairing: 16 addresses, then 16 data beats
        for (int i = 0; i < 16; i++) begin
            s = idle_stim();
            s.we = 1'b1;
            s.addr = 32'h0100_4000 + 32'(i * 32);
            step_cycle(s);
        end
        chk("pair_count_full", DW'(wq_count), DW'(16));
        for (int i = 0; i < 16; i++) begin
            s = idle_stim();
            s.wdv = 1'b1;
            s.wd = DW'(i);
            step_cycle(s);
        end
        chk("pair_count_empty", DW'(wq_count), zw);
        for (int i = 0; i < 16; i++) read_expect("pair_rb", 32'h0100_4000 + 32'(i * 32), DW'(i), 1'b0);

        // Out-of-window read and write
        apply_reset(2);
        read_expect("oob_rd", 32'h0080_0000, zw, 1'b1);
        chk("oob_err_cnt1", DW'(err_cnt), DW'(1));
        s = idle_stim(); s.we = 1'b1; s.addr = 32'h0080_001C; step_cycle(s);
        s = idle_stim(); s.wdv = 1'b1; s.wd = {DW{1'b1}}; step_cycle(s);
        chk("oob_err_cnt2", DW'(err_cnt), DW'(2));
        read_expect("oob_nowrite", BASE, q0, 1'b0);

        // Overflow: 17 addresses into a 16-deep queue
        for (int i = 0; i < 17; i++) begin
            s = idle_stim();
            s.we = 1'b1;
            s.addr = 32'h0100_4000 + 32'(i * 32);
            step_cycle(s);
        end
        chk("ovf_flag", DW'(wq_overflow), DW'(1));
        chk("ovf_count", DW'(wq_count), DW'(16));
        for (int i = 0; i < 16; i++) begin
            s = idle_stim();
            s.wdv = 1'b1;
            s.wd = DW'(32'hA0 + 32'(i));
            step_cycle(s);
        end
        // Underflow: one more beat than addresses
        s = idle_stim(); s.wdv = 1'b1; s.wd = rand_word(); step_cycle(s);
        chk("unf_flag", DW'(wq_underflow), DW'(1));
        // Bypass on an empty queue
        s = idle_stim(); s.we = 1'b1; s.wdv = 1'b1; s.addr = 32'h0100_6000; s.wd = {8{32'h5A5A_1234}};
        step_cycle(s);
        chk("bypass_count", DW'(wq_count), zw);
        read_expect("bypass_rb", 32'h0100_6000, {8{32'h5A5A_1234}}, 1'b0);

        // Randomised traffic on a small hot window plus both out-of-window sides
        apply_reset(2);
        for (int i = 0; i < 600; i++) begin
            s = idle_stim();
            case ($urandom_range(0, 9))
                0:       s.addr = BASE - 32'($urandom_range(1, 256));
                1:       s.addr = BASE + 32'(DEPTH * 32) + 32'($urandom_range(0, 255));
                default: s.addr = BASE + 32'($urandom_range(0, 31) * 32) + 32'($urandom_range(0, 31));
            endcase
            s.re  = ($urandom_range(0, 1) == 0);
            s.we  = ($urandom_range(0, 3) == 0);
            s.wdv = ($urandom_range(0, 3) == 0);
            s.wd  = rand_word();
            s.ie  = ($urandom_range(0, 9) == 0);
            s.ii  = 10'($urandom_range(0, 31));
            s.id  = rand_word();
            step_cycle(s);
        end
        idle_cycles(LAT + 1);

        // Reset with reads in flight
        for (int i = 0; i < 3; i++) begin
            s = idle_stim();
            s.re = 1'b1;
            s.addr = 32'h0100_2000 + 32'(i * 32);
            step_cycle(s);
        end
        idle_cycles(1);
        apply_reset(2);
        beats = 0;
        idle_cycles(10);
        chk("post_reset_beats", DW'(beats), zw);
        decode(32'h0100_2000, ridx, roob);
        read_expect("retain", 32'h0100_2000, pat_p, DW'(roob) == zw ? 1'b0 : 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pim_dram_resp_model.md
Name: pim_dram_resp_model

Overview:
Parametrised, synthesizable DRAM-side responder that sits opposite Device_top on the memory bus. It replaces hand-timed `rd_data_valid` / `data_bus_from_memory` driving with a real memory model:
- reads return stored data after a configurable fixed latency;
- write addresses are queued and paired with later `is_PIM_result` data beats.

Several instances can be placed side by side with different `BASE_ADDR` windows, e.g. descriptor region and tensor region.

Parameters:
- DATA_W, 256, bus data width in bits; multiple of 8, DATA_W/8 a power of two.
- ADDR_W, 32, byte address width.
- MEM_DEPTH, 1024, number of DATA_W words in the window; power of two.
- BASE_ADDR, 32'h0100_0000, byte address of word 0.
- RD_LATENCY, 4, cycles from accepted read to response beat; range 1..16.
- WQ_DEPTH, 16, write-address FIFO entries; power of two, at least 2.

Ports:
- clk  in  1  clock.
- rst_x  in  1  reset; asynchronous assert, active-low.
- read_en  in  1  read command, one word per cycle.
- write_en  in  1  write-address command.
- addr_in  in  ADDR_W  byte address for read_en/write_en.
- wr_data_valid  in  1  write data beat (wired from is_PIM_result).
- wr_data  in  DATA_W  write data (wired from PIM_result_to_DRAM).
- init_en  in  1  backdoor preload strobe.
- init_idx  in  $clog2(MEM_DEPTH)  backdoor word index.
- init_data  in  DATA_W  backdoor data.
- rd_data_valid  out  1  response beat valid.
- data_bus_from_memory  out  DATA_W  response data.
- rd_err  out  1  pulse aligned with a response beat whose read was out of window.
- wq_count  out  $clog2(WQ_DEPTH)+1  write-address FIFO occupancy.
- wq_overflow  out  1  sticky; a write_en was dropped because the FIFO was full.
- wq_underflow  out  1  sticky; a wr_data_valid arrived with no address available.
- err_cnt  out  16  saturating count of out-of-window accesses (reads and writes).

Behaviour:
- Reset values: every output is 0; the read pipeline and the FIFO are cleared. The memory array is not reset. Reset asserted mid-operation discards in-flight reads and queued addresses, and clears the sticky flags.
- Address decode: idx = (addr_in - BASE_ADDR) >> log2(DATA_W/8). Low byte-offset bits are ignored. The access is in-window iff addr_in >= BASE_ADDR and idx < MEM_DEPTH.
- Read path:
  - A read_en in cycle N reads mem[idx] in cycle N.
  - rd_data_valid=1 with that data in cycle N+RD_LATENCY, via a RD_LATENCY-stage valid/data/err shift pipeline.
  - Back-to-back reads stream one beat per cycle in issue order. No backpressure.
  - Out-of-window read: data=0, rd_err=1 on its beat, err_cnt+1.
  - rd_data_valid=0 implies data_bus_from_memory=0.
- Write address queue:
  - write_en pushes idx plus an oob bit.
  - Push while full and no simultaneous pop: entry dropped, wq_overflow set.
  - Push and pop in the same cycle while full: both succeed; occupancy stays at WQ_DEPTH.
  - An out-of-window write increments err_cnt at push time and is still queued, so that it consumes its data beat.
- Write data:
  - wr_data_valid pops the FIFO head and writes mem[head_idx]=wr_data, unless the head is oob, in which case the data is discarded.
  - FIFO empty plus same-cycle write_en: bypass; the data is written to the pushed address and occupancy stays 0.
  - FIFO empty with no write_en: beat dropped, wq_underflow set.
  - The memory write takes effect at the clock edge.
- Hazards and init:
  - A read in the same cycle as a write to the same idx returns the old data (read-before-write).
  - init_en writes mem[init_idx] and has priority over a same-cycle wr_data write to the same idx.
  - init_en performs no FIFO action.
- read_en and write_en together: both are accepted independently.
- err_cnt saturates at 16'hFFFF.

Decomposition:
- Package pim_mem_pkg holds:
  - constants DATA_W_DEF=256 and ADDR_W_DEF=32;
  - a function that maps a byte address to a word index;
  - the typedef of the write-queue entry struct {idx, oob}.
- One sub-module, pim_wq_fifo, implements the synchronous FIFO with count, full, empty, and same-cycle push/pop on full.
- Decode, the read latency pipeline and the memory array stay in the top.

Test Plan:
- Latency: preload idx 0x100 = 256'h3e4f…3e40, read_en at addr 0x0100_2000 in cycle N -> rd_data_valid exactly at N+4 with that data and rd_err=0.
- Stream: 256 consecutive reads at 0x0100_2000+i*32 -> 256 contiguous beats in order, no gap, with the last beat at issue+255+4.
- Write pairing: 16 write_en at 0x0100_4000+i*32, then 16 wr_data_valid beats with data=i -> wq_count rises to 16 then returns to 0; read-back of each address returns i.
- Window errors: read at 0x0080_0000 -> beat with data 0, rd_err=1, err_cnt=1. A write at 0x0080_001C plus its data beat -> no memory change, err_cnt=2.
- FIFO edges:
  - 17 write_en with WQ_DEPTH=16 -> wq_overflow=1, count=16.
  - wr_data_valid with empty FIFO -> wq_underflow=1.
  - Same-cycle write_en and wr_data_valid with empty FIFO -> bypass write lands.
- Reset mid-read: issue 3 reads, assert rst_x low 2 cycles later -> no rd_data_valid after release; preloaded memory contents retained.
